exe_alu_md: RTL and testbench

- Execute-stage datapath unit. Consumes the 5-bit ALU control code produced by the ALU decoder.
- Performs single-cycle integer ALU operations, plus multi-cycle MULT/MULTU/DIV/DIVU into a HI/LO result pair.
- Raises a stall while a multiply or divide is in flight, so the hazard unit freezes F/D/E.
- Drives the EX/MEM pipeline register and the HI/LO register file.

---
 rtl/exe_alu_md.sv | 180 ++++++++++++++++++
 tb/tb_exe_alu_md.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_alu_md.sv
// Execute-stage ALU (combinational) plus a multi-cycle MULT/MULTU/DIV/DIVU unit writing HI/LO.
// Multiply finishes 2 cycles after accept, divide 33; md_stall holds F/D/E until the DONE cycle.
module exe_alu_md #(
   parameter int DATA_W    = 32,
   parameter int DIV_ITERS = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [4:0]        aluctrl,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic [4:0]        sa,
   input  logic              ov_check,
   input  logic [1:0]        md_op,
   input  logic              md_valid,
   input  logic              flush,
   output logic [DATA_W-1:0] alu_result,
   output logic              overflow,
   output logic              md_stall,
   output logic              md_done,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out
);
   localparam logic [4:0] ALU_AND  = 5'd0,  ALU_OR   = 5'd1,  ALU_ADD  = 5'd2,
                          ALU_XOR  = 5'd3,  ALU_NOR  = 5'd4,  ALU_SUB  = 5'd6,
                          ALU_SLT  = 5'd7,  ALU_SLTU = 5'd8,  ALU_SLL  = 5'd9,
                          ALU_SRL  = 5'd10, ALU_SRA  = 5'd11, ALU_SLLV = 5'd12,
                          ALU_SRLV = 5'd13, ALU_SRAV = 5'd14;
   localparam int CNT_W = $clog2(DIV_ITERS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_e;

   md_state_e         state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d;
   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [1:0]        op_q, op_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [DATA_W-1:0] sum, diff;
   assign sum  = src_a + src_b;
   assign diff = src_a - src_b;

   always_comb begin
      alu_result = '0;
      overflow   = 1'b0;
      case (aluctrl)
         ALU_ADD: begin
            alu_result = sum;
            overflow   = ov_check & (src_a[DATA_W-1] == src_b[DATA_W-1])
                                  & (sum[DATA_W-1] != src_a[DATA_W-1]);
         end
         ALU_SUB: begin
            alu_result = diff;
            overflow   = ov_check & (src_a[DATA_W-1] != src_b[DATA_W-1])
                                  & (diff[DATA_W-1] != src_a[DATA_W-1]);
         end
         ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
         ALU_AND:  alu_result = src_a & src_b;
         ALU_OR:   alu_result = src_a | src_b;
         ALU_XOR:  alu_result = src_a ^ src_b;
         ALU_NOR:  alu_result = ~(src_a | src_b);
         ALU_SLL:  alu_result = src_b << sa;
         ALU_SRL:  alu_result = src_b >> sa;
         ALU_SRA:  alu_result = $signed(src_b) >>> sa;
         ALU_SLLV: alu_result = src_b << src_a[4:0];
         ALU_SRLV: alu_result = src_b >> src_a[4:0];
         ALU_SRAV: alu_result = $signed(src_b) >>> src_a[4:0];
         default:  alu_result = '0;
      endcase
   end

   // md_op[0] = 0 selects the signed variants (MULT, DIV)
   logic                op_signed, q_neg, r_neg;
   logic [DATA_W-1:0]   b_mag;
   logic [2*DATA_W-1:0] mul_a, mul_b, product;
   logic [DATA_W:0]     trial;

   assign op_signed = ~op_q[0];
   assign b_mag     = (op_signed && b_q[DATA_W-1]) ? -b_q : b_q;
   assign mul_a     = {{DATA_W{op_signed & a_q[DATA_W-1]}}, a_q};
   assign mul_b     = {{DATA_W{op_signed & b_q[DATA_W-1]}}, b_q};
   assign product   = mul_a * mul_b;
   assign trial     = {rem_q, quo_q[DATA_W-1]} - {1'b0, b_mag};
   assign q_neg     = op_signed & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
   assign r_neg     = op_signed & a_q[DATA_W-1];

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      md_stall = 1'b0;
      md_done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (md_valid && !flush) begin
               md_stall = 1'b1;
               a_d      = src_a;
               b_d      = src_b;
               op_d     = md_op;
               cnt_d    = '0;
               rem_d    = '0;
               quo_d    = (!md_op[0] && src_a[DATA_W-1]) ? -src_a : src_a;
               state_d  = md_op[1] ? S_DIV : S_MUL;
            end
         end
         S_MUL: begin
            md_stall       = 1'b1;
            {rem_d, quo_d} = product;
            state_d        = S_DONE;
         end
         S_DIV: begin
            md_stall = 1'b1;
            // Borrow out of the trial subtract means the divisor did not fit
            if (!trial[DATA_W]) begin
               rem_d = trial[DATA_W-1:0];
               quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
               rem_d = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
               quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (!flush) begin
               md_done = 1'b1;
               if (!op_q[1]) begin
                  hi_d = rem_q;
                  lo_d = quo_q;
               end else if (b_q == '0) begin
                  hi_d = a_q;
                  lo_d = '1;
               end else begin
                  hi_d = r_neg ? -rem_q : rem_q;
                  lo_d = q_neg ? -quo_q : quo_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi_out = hi_q;
   assign lo_out = lo_q;
endmodule

// File: tb/tb_exe_alu_md.sv
// Directed bench for exe_alu_md: ALU vector table, mult/div vector table, flush and async-reset sequences.
module tb_exe_alu_md;
   localparam logic [4:0] C_AND  = 5'd0,  C_OR   = 5'd1,  C_ADD  = 5'd2,
                          C_XOR  = 5'd3,  C_NOR  = 5'd4,  C_SUB  = 5'd6,
                          C_SLT  = 5'd7,  C_SLTU = 5'd8,  C_SLL  = 5'd9,
                          C_SRL  = 5'd10, C_SRA  = 5'd11, C_SLLV = 5'd12,
                          C_SRLV = 5'd13, C_SRAV = 5'd14, C_BAD  = 5'd31;
   localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

   logic        clk, resetn;
   logic [4:0]  aluctrl, sa;
   logic [31:0] src_a, src_b;
   logic        ov_check, md_valid, flush;
   logic [1:0]  md_op;
   logic [31:0] alu_result, hi_out, lo_out;
   logic        overflow, md_stall, md_done;

   int checks   = 0;
   int failures = 0;

   exe_alu_md #(.DATA_W(32), .DIV_ITERS(32)) dut (
      .clk(clk), .resetn(resetn), .aluctrl(aluctrl), .src_a(src_a), .src_b(src_b),
      .sa(sa), .ov_check(ov_check), .md_op(md_op), .md_valid(md_valid), .flush(flush),
      .alu_result(alu_result), .overflow(overflow), .md_stall(md_stall),
      .md_done(md_done), .hi_out(hi_out), .lo_out(lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic        ov;
      logic [31:0] exp_res;
      logic        exp_ov;
   } alu_vec_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          lat;
   } md_vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_md(input md_vec_t v, input int id);
      int k;
      int stalls;
      bit seen;
      @(negedge clk);
      md_op    = v.op;
      src_a    = v.a;
      src_b    = v.b;
      md_valid = 1'b1;
      #1 chk($sformatf("md%0d accept_stall", id), {31'b0, md_stall}, 32'd1);
      stalls = 1;
      seen   = 1'b0;
      k      = 0;
      while (!seen && k < 60) begin
         @(negedge clk);
         #1;
         k++;
         if (md_done) seen = 1'b1;
         else if (md_stall) stalls++;
      end
      chk($sformatf("md%0d done_seen", id), {31'b0, seen}, 32'd1);
      chk($sformatf("md%0d latency", id), k, v.lat);
      chk($sformatf("md%0d stall_cycles", id), stalls, v.lat);
      chk($sformatf("md%0d done_stall", id), {31'b0, md_stall}, 32'd0);
      @(negedge clk);
      md_valid = 1'b0;
      #1;
      chk($sformatf("md%0d hi", id), hi_out, v.exp_hi);
      chk($sformatf("md%0d lo", id), lo_out, v.exp_lo);
      chk($sformatf("md%0d idle_stall", id), {31'b0, md_stall}, 32'd0);
   endtask

   alu_vec_t alu_tbl[18];
   md_vec_t  md_tbl[8];
   md_vec_t  mv;

   initial begin
      alu_tbl[0]  = '{C_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  1'b1, 32'h80000000, 1'b1};
      alu_tbl[1]  = '{C_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h80000000, 1'b0};
      alu_tbl[2]  = '{C_SRA,  32'h00000000, 32'h80000000, 5'd4,  1'b0, 32'hF8000000, 1'b0};
      alu_tbl[3]  = '{C_SLTU, 32'h00000001, 32'hFFFFFFFF, 5'd0,  1'b0, 32'h00000001, 1'b0};
      alu_tbl[4]  = '{C_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h00000001, 1'b0};
      alu_tbl[5]  = '{C_SLT,  32'h00000001, 32'hFFFFFFFF, 5'd0,  1'b0, 32'h00000000, 1'b0};
      alu_tbl[6]  = '{C_SUB,  32'h80000000, 32'h00000001, 5'd0,  1'b1, 32'h7FFFFFFF, 1'b1};
      alu_tbl[7]  = '{C_SUB,  32'h00000005, 32'h00000003, 5'd0,  1'b1, 32'h00000002, 1'b0};
      alu_tbl[8]  = '{C_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'hF000F000, 1'b0};
      alu_tbl[9]  = '{C_OR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'hFFF0FFF0, 1'b0};
      alu_tbl[10] = '{C_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'h0FF00FF0, 1'b0};
      alu_tbl[11] = '{C_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'h000F000F, 1'b0};
      alu_tbl[12] = '{C_SLL,  32'h00000000, 32'h00000001, 5'd31, 1'b0, 32'h80000000, 1'b0};
      alu_tbl[13] = '{C_SRL,  32'h00000000, 32'h80000000, 5'd4,  1'b0, 32'h08000000, 1'b0};
      alu_tbl[14] = '{C_SLLV, 32'h00000023, 32'h00000001, 5'd0,  1'b0, 32'h00000008, 1'b0};
      alu_tbl[15] = '{C_SRAV, 32'h00000004, 32'h80000000, 5'd9,  1'b0, 32'hF8000000, 1'b0};
      alu_tbl[16] = '{C_SRLV, 32'h00000024, 32'hF0000000, 5'd0,  1'b0, 32'h0F000000, 1'b0};
      alu_tbl[17] = '{C_BAD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  1'b1, 32'h00000000, 1'b0};

      md_tbl[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 2};
      md_tbl[1] = '{OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 2};
      md_tbl[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
      md_tbl[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
      md_tbl[4] = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 33};
      md_tbl[5] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
      md_tbl[6] = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 33};
      md_tbl[7] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 33};

      resetn = 1'b0; aluctrl = C_BAD; sa = '0; src_a = '0; src_b = '0;
      ov_check = 1'b0; md_op = '0; md_valid = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset hi", hi_out, 32'h0);
      chk("reset lo", lo_out, 32'h0);
      chk("reset stall", {31'b0, md_stall}, 32'd0);
      chk("reset done", {31'b0, md_done}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         aluctrl  = alu_tbl[i].ctrl;
         src_a    = alu_tbl[i].a;
         src_b    = alu_tbl[i].b;
         sa       = alu_tbl[i].sh;
         ov_check = alu_tbl[i].ov;
         #1;
         chk($sformatf("alu%0d result", i), alu_result, alu_tbl[i].exp_res);
         chk($sformatf("alu%0d overflow", i), {31'b0, overflow}, {31'b0, alu_tbl[i].exp_ov});
      end
      ov_check = 1'b0;

      for (int i = 0; i < 8; i++) run_md(md_tbl[i], i);

      // flush on the accept cycle must not start an operation
      @(negedge clk);
      md_op = OP_MULT; src_a = 32'd3; src_b = 32'd3; md_valid = 1'b1; flush = 1'b1;
      #1 chk("flush_accept stall", {31'b0, md_stall}, 32'd0);
      @(negedge clk);
      md_valid = 1'b0; flush = 1'b0;
      #1 chk("flush_accept idle", {31'b0, md_stall}, 32'd0);
      @(negedge clk);
      #1 chk("flush_accept no_done", {31'b0, md_done}, 32'd0);

      // squash a DIVU at iteration 10
      @(negedge clk);
      md_op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3; md_valid = 1'b1;
      repeat (10) @(negedge clk);
      #1 chk("flush_mid stall_before", {31'b0, md_stall}, 32'd1);
      flush = 1'b1; md_valid = 1'b0;
      #1 chk("flush_mid no_done", {31'b0, md_done}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_mid idle_stall", {31'b0, md_stall}, 32'd0);
      chk("flush_mid hi_kept", hi_out, 32'h00000002);
      chk("flush_mid lo_kept", lo_out, 32'h0000000E);
      repeat (3) begin
         @(negedge clk);
         #1 chk("flush_mid later_no_done", {31'b0, md_done}, 32'd0);
      end
      mv = '{OP_MULT, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 2};
      run_md(mv, 20);

      // asynchronous reset in the middle of a divide
      @(negedge clk);
      md_op = OP_DIV; src_a = 32'd1000; src_b = 32'd3; md_valid = 1'b1;
      repeat (5) @(negedge clk);
      #2;
      resetn = 1'b0; md_valid = 1'b0;
      #1;
      chk("arst stall", {31'b0, md_stall}, 32'd0);
      chk("arst hi", hi_out, 32'h0);
      chk("arst lo", lo_out, 32'h0);
      chk("arst done", {31'b0, md_done}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      #1 chk("arst released idle", {31'b0, md_stall}, 32'd0);
      @(negedge clk);
      #1 chk("arst released no_done", {31'b0, md_done}, 32'd0);
      mv = '{OP_DIVU, 32'h00000009, 32'h00000003, 32'h00000000, 32'h00000003, 33};
      run_md(mv, 21);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
